mem_xfer_seq: RTL and testbench

Parametrised transfer sequencer for the memory-load and memory-copy paths. It accepts a byte-addressed transfer request (base address, length in bytes) and emits a stream of beats toward the memory port. For each beat it picks the widest access (word, halfword or byte) that is naturally aligned at the current address and fits in the remaining length. It supports downstream back-pressure, abort, and a one-cycle completion pulse, and sits between the loader/DMA control FSM and the data-memory write port.

---
 rtl/mem_xfer_seq.sv | 138 +++++++++++++
 tb/tb_mem_xfer_seq.sv | 466 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_xfer_seq.sv
// Byte-addressed transfer sequencer: splits a (base, len) request into naturally
// aligned word/halfword/byte beats with back-pressure, abort and a completion pulse.
module mem_xfer_seq #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              abort_i,
    input  logic              beat_ready_i,
    output logic              busy_o,
    output logic              beat_valid_o,
    output logic [ADDR_W-1:0] beat_addr_o,
    output logic [1:0]        beat_size_o,
    output logic [3:0]        beat_be_o,
    output logic              beat_last_o,
    output logic              done_o,
    output logic              aborted_o,
    output logic [LEN_W-1:0]  count_o
);

    // state  | meaning
    // S_IDLE | waiting for start
    // S_RUN  | issuing beats
    // S_DONE | one-cycle completion pulse
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [LEN_W-1:0]  count_q, count_d;
    logic              aborted_q, aborted_d;

    logic [1:0] size_sel;
    logic [2:0] size_bytes;
    logic [3:0] be_sel;
    logic       last_sel;
    logic       run;
    logic       hs;

    // Widest access that is naturally aligned at addr and fits in the remaining bytes
    always_comb begin
        size_sel   = 2'd0;
        size_bytes = 3'd1;
        be_sel     = 4'b0001 << addr_q[1:0];
        if ((addr_q[1:0] == 2'b00) && (rem_q >= LEN_W'(4))) begin
            size_sel   = 2'd2;
            size_bytes = 3'd4;
            be_sel     = 4'b1111;
        end else if (!addr_q[0] && (rem_q >= LEN_W'(2))) begin
            size_sel   = 2'd1;
            size_bytes = 3'd2;
            be_sel     = 4'b0011 << addr_q[1:0];
        end
    end

    assign last_sel = (rem_q == LEN_W'(size_bytes));
    assign run      = (state_q == S_RUN);
    assign hs       = run && beat_ready_i;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        count_d   = count_q;
        aborted_d = aborted_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    count_d   = '0;
                    aborted_d = 1'b0;
                    if (len_i != '0) begin
                        addr_d  = base_addr_i;
                        rem_d   = len_i;
                        state_d = S_RUN;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                // abort wins over a simultaneous handshake; that beat is dropped
                if (abort_i) begin
                    aborted_d = 1'b1;
                    state_d   = S_DONE;
                end else if (hs) begin
                    addr_d  = addr_q + ADDR_W'(size_bytes);
                    rem_d   = rem_q - LEN_W'(size_bytes);
                    count_d = count_q + LEN_W'(size_bytes);
                    if (last_sel) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            count_q   <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            count_q   <= count_d;
            aborted_q <= aborted_d;
        end
    end

    // Beat fields are forced to zero outside RUN so idle/reset outputs read as 0
    assign busy_o       = (state_q != S_IDLE);
    assign beat_valid_o = run;
    assign beat_addr_o  = run ? addr_q : '0;
    assign beat_size_o  = run ? size_sel : 2'd0;
    assign beat_be_o    = run ? be_sel : 4'b0000;
    assign beat_last_o  = run && last_sel;
    assign done_o       = (state_q == S_DONE);
    assign aborted_o    = aborted_q;
    assign count_o      = count_q;

endmodule

// File: tb/tb_mem_xfer_seq.sv
// Scoreboard bench for mem_xfer_seq: expected beats queued at stimulus time,
// observed handshakes collected by a monitor and compared per scenario.
module tb_mem_xfer_seq;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start_i, abort_i, beat_ready_i;
    logic [31:0] base_addr_i;
    logic [15:0] len_i;
    logic        busy_o, beat_valid_o, beat_last_o, done_o, aborted_o;
    logic [31:0] beat_addr_o;
    logic [1:0]  beat_size_o;
    logic [3:0]  beat_be_o;
    logic [15:0] count_o;

    logic        start8, abort8, ready8;
    logic [7:0]  base8;
    logic [15:0] len8;
    logic        busy8, valid8, last8, done8, aborted8;
    logic [7:0]  addr8;
    logic [1:0]  size8;
    logic [3:0]  be8;
    logic [15:0] count8;

    mem_xfer_seq #(.ADDR_W(32), .LEN_W(16)) dut (
        .clk(clk), .rstn(rstn), .start_i(start_i), .base_addr_i(base_addr_i),
        .len_i(len_i), .abort_i(abort_i), .beat_ready_i(beat_ready_i),
        .busy_o(busy_o), .beat_valid_o(beat_valid_o), .beat_addr_o(beat_addr_o),
        .beat_size_o(beat_size_o), .beat_be_o(beat_be_o), .beat_last_o(beat_last_o),
        .done_o(done_o), .aborted_o(aborted_o), .count_o(count_o)
    );

    mem_xfer_seq #(.ADDR_W(8), .LEN_W(16)) dut8 (
        .clk(clk), .rstn(rstn), .start_i(start8), .base_addr_i(base8),
        .len_i(len8), .abort_i(abort8), .beat_ready_i(ready8),
        .busy_o(busy8), .beat_valid_o(valid8), .beat_addr_o(addr8),
        .beat_size_o(size8), .beat_be_o(be8), .beat_last_o(last8),
        .done_o(done8), .aborted_o(aborted8), .count_o(count8)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [1:0]  s;
        logic [3:0]  be;
        logic        l;
    } beat_t;

    beat_t sb[$];
    beat_t obs[$];
    beat_t ex, ob;
    int    cyc = 0;
    int    last_hs_cyc = -1;
    int    checks = 0;
    int    errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rstn && beat_valid_o && beat_ready_i && !abort_i) begin
            obs.push_back(beat_t'({beat_addr_o, beat_size_o, beat_be_o, beat_last_o}));
            if (beat_last_o) last_hs_cyc <= cyc;
        end
    end

    function automatic beat_t mk(logic [31:0] a, logic [1:0] s, logic [3:0] be, logic l);
        return {a, s, be, l};
    endfunction

    task automatic issue_start(input logic [31:0] b, input logic [15:0] l, output int scyc);
        @(posedge clk);
        #1 start_i = 1'b1; base_addr_i = b; len_i = l;
        @(posedge clk);
        #1 start_i = 1'b0;
        scyc = cyc;
    endtask

    task automatic wait_done(output bit seen, output int dcyc);
        seen = 1'b0;
        dcyc = -1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (done_o) begin
                seen = 1'b1;
                dcyc = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy_o, beat_valid_o, beat_addr_o, beat_size_o, beat_be_o, beat_last_o,
             done_o, aborted_o, count_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b valid=%b addr=%h size=%0d be=%b last=%b done=%b ab=%b cnt=%0d, expected all 0",
                     busy_o, beat_valid_o, beat_addr_o, beat_size_o, beat_be_o, beat_last_o,
                     done_o, aborted_o, count_o);
        end
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: busy=%b done=%b, expected 0 0", busy_o, done_o);
        end
    endtask

    task automatic test_aligned;
        int scyc, dcyc;
        bit seen;
        beat_ready_i = 1'b1;
        sb.push_back(mk(32'h100, 2'd2, 4'b1111, 1'b0));
        sb.push_back(mk(32'h104, 2'd2, 4'b1111, 1'b1));
        issue_start(32'h100, 16'd8, scyc);
        @(negedge clk);
        checks++;
        if (beat_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL aligned_first_valid: got %b expected 1", beat_valid_o);
        end
        wait_done(seen, dcyc);
        checks++;
        if (!seen || dcyc != scyc + 2 || dcyc != last_hs_cyc + 1) begin
            errors++;
            $display("FAIL aligned_done_timing: seen=%b done_cyc=%0d, expected cycle %0d", seen, dcyc, scyc + 2);
        end
        checks++;
        if (count_o !== 16'd8 || aborted_o !== 1'b0) begin
            errors++;
            $display("FAIL aligned_count: count=%0d aborted=%b, expected 8 0", count_o, aborted_o);
        end
        while (sb.size() != 0) begin
            ex = sb.pop_front();
            checks++;
            if (obs.size() == 0) begin
                errors++;
                $display("FAIL aligned_beat: missing, expected %h", ex);
            end else begin
                ob = obs.pop_front();
                if (ob !== ex) begin
                    errors++;
                    $display("FAIL aligned_beat: got %h expected %h (addr,size,be,last)", ob, ex);
                end
            end
        end
        checks++;
        if (obs.size() != 0) begin
            errors++;
            $display("FAIL aligned_extra_beats: got %0d expected 0", obs.size());
            obs.delete();
        end
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL aligned_idle_after: busy=%b done=%b, expected 0 0", busy_o, done_o);
        end
    endtask

    task automatic test_unaligned;
        int scyc, dcyc;
        bit seen;
        beat_ready_i = 1'b1;
        sb.push_back(mk(32'h101, 2'd0, 4'b0010, 1'b0));
        sb.push_back(mk(32'h102, 2'd1, 4'b1100, 1'b0));
        sb.push_back(mk(32'h104, 2'd2, 4'b1111, 1'b1));
        issue_start(32'h101, 16'd7, scyc);
        wait_done(seen, dcyc);
        checks++;
        if (!seen || dcyc != scyc + 3) begin
            errors++;
            $display("FAIL unaligned_done_timing: seen=%b done_cyc=%0d, expected cycle %0d", seen, dcyc, scyc + 3);
        end
        checks++;
        if (count_o !== 16'd7) begin
            errors++;
            $display("FAIL unaligned_count: got %0d expected 7", count_o);
        end
        while (sb.size() != 0) begin
            ex = sb.pop_front();
            checks++;
            if (obs.size() == 0) begin
                errors++;
                $display("FAIL unaligned_beat: missing, expected %h", ex);
            end else begin
                ob = obs.pop_front();
                if (ob !== ex) begin
                    errors++;
                    $display("FAIL unaligned_beat: got %h expected %h (addr,size,be,last)", ob, ex);
                end
            end
        end
        checks++;
        if (obs.size() != 0) begin
            errors++;
            $display("FAIL unaligned_extra_beats: got %0d expected 0", obs.size());
            obs.delete();
        end
    endtask

    task automatic test_stall;
        int scyc, dcyc;
        bit seen;
        beat_t held;
        beat_ready_i = 1'b0;
        sb.push_back(mk(32'h102, 2'd1, 4'b1100, 1'b0));
        sb.push_back(mk(32'h104, 2'd0, 4'b0001, 1'b1));
        issue_start(32'h102, 16'd3, scyc);
        held = mk(32'h102, 2'd1, 4'b1100, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (!beat_valid_o || beat_t'({beat_addr_o, beat_size_o, beat_be_o, beat_last_o}) !== held) begin
                errors++;
                $display("FAIL stall_hold[%0d]: valid=%b beat=%h expected %h", i, beat_valid_o,
                         beat_t'({beat_addr_o, beat_size_o, beat_be_o, beat_last_o}), held);
            end
        end
        @(posedge clk);
        #1 beat_ready_i = 1'b1;
        wait_done(seen, dcyc);
        checks++;
        if (!seen || dcyc != last_hs_cyc + 1) begin
            errors++;
            $display("FAIL stall_done_timing: seen=%b done_cyc=%0d, expected %0d", seen, dcyc, last_hs_cyc + 1);
        end
        checks++;
        if (count_o !== 16'd3) begin
            errors++;
            $display("FAIL stall_count: got %0d expected 3", count_o);
        end
        while (sb.size() != 0) begin
            ex = sb.pop_front();
            checks++;
            if (obs.size() == 0) begin
                errors++;
                $display("FAIL stall_beat: missing, expected %h", ex);
            end else begin
                ob = obs.pop_front();
                if (ob !== ex) begin
                    errors++;
                    $display("FAIL stall_beat: got %h expected %h (addr,size,be,last)", ob, ex);
                end
            end
        end
        checks++;
        if (obs.size() != 0) begin
            errors++;
            $display("FAIL stall_extra_beats: got %0d expected 0", obs.size());
            obs.delete();
        end
    endtask

    task automatic test_zero_len;
        int scyc;
        beat_ready_i = 1'b1;
        issue_start(32'h55, 16'd0, scyc);
        @(negedge clk);
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b1 || beat_valid_o !== 1'b0 ||
            count_o !== 16'd0 || aborted_o !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_done: done=%b busy=%b valid=%b count=%0d ab=%b, expected 1 1 0 0 0",
                     done_o, busy_o, beat_valid_o, count_o, aborted_o);
        end
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || beat_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_after: busy=%b done=%b valid=%b, expected 0 0 0", busy_o, done_o, beat_valid_o);
        end
        checks++;
        if (obs.size() != 0) begin
            errors++;
            $display("FAIL zero_len_beats: got %0d expected 0", obs.size());
            obs.delete();
        end
    endtask

    task automatic test_wrap;
        @(posedge clk);
        #1 start8 = 1'b1; base8 = 8'hFE; len8 = 16'd4;
        @(posedge clk);
        #1 start8 = 1'b0;
        @(negedge clk);
        checks++;
        if ({valid8, addr8, size8, be8, last8} !== {1'b1, 8'hFE, 2'd1, 4'b1100, 1'b0}) begin
            errors++;
            $display("FAIL wrap_beat0: valid=%b addr=%h size=%0d be=%b last=%b, expected 1 fe 1 1100 0",
                     valid8, addr8, size8, be8, last8);
        end
        @(negedge clk);
        checks++;
        if ({valid8, addr8, size8, be8, last8} !== {1'b1, 8'h00, 2'd1, 4'b0011, 1'b1}) begin
            errors++;
            $display("FAIL wrap_beat1: valid=%b addr=%h size=%0d be=%b last=%b, expected 1 00 1 0011 1",
                     valid8, addr8, size8, be8, last8);
        end
        @(negedge clk);
        checks++;
        if (done8 !== 1'b1 || count8 !== 16'd4 || aborted8 !== 1'b0) begin
            errors++;
            $display("FAIL wrap_done: done=%b count=%0d ab=%b, expected 1 4 0", done8, count8, aborted8);
        end
    endtask

    task automatic test_abort;
        int scyc;
        beat_ready_i = 1'b1;
        sb.push_back(mk(32'h0, 2'd2, 4'b1111, 1'b0));
        sb.push_back(mk(32'h4, 2'd2, 4'b1111, 1'b0));
        issue_start(32'h0, 16'd16, scyc);
        start_i = 1'b1; base_addr_i = 32'h80; len_i = 16'd4;
        @(posedge clk);
        #1 start_i = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (count_o !== 16'd8 || beat_valid_o !== 1'b1 || beat_addr_o !== 32'h8) begin
            errors++;
            $display("FAIL abort_before: count=%0d valid=%b addr=%h, expected 8 1 8", count_o, beat_valid_o, beat_addr_o);
        end
        abort_i = 1'b1;
        @(posedge clk);
        #1 abort_i = 1'b0;
        checks++;
        if (done_o !== 1'b1 || aborted_o !== 1'b1 || count_o !== 16'd8 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL abort_done: done=%b ab=%b count=%0d busy=%b, expected 1 1 8 1", done_o, aborted_o, count_o, busy_o);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || aborted_o !== 1'b1) begin
            errors++;
            $display("FAIL abort_after: done=%b busy=%b ab=%b, expected 0 0 1", done_o, busy_o, aborted_o);
        end
        while (sb.size() != 0) begin
            ex = sb.pop_front();
            checks++;
            if (obs.size() == 0) begin
                errors++;
                $display("FAIL abort_beat: missing, expected %h", ex);
            end else begin
                ob = obs.pop_front();
                if (ob !== ex) begin
                    errors++;
                    $display("FAIL abort_beat: got %h expected %h (addr,size,be,last)", ob, ex);
                end
            end
        end
        checks++;
        if (obs.size() != 0) begin
            errors++;
            $display("FAIL abort_extra_beats: got %0d expected 0", obs.size());
            obs.delete();
        end
    endtask

    task automatic test_back_to_back;
        int scyc, dcyc;
        bit seen;
        beat_ready_i = 1'b1;
        sb.push_back(mk(32'h100, 2'd2, 4'b1111, 1'b0));
        sb.push_back(mk(32'h104, 2'd2, 4'b1111, 1'b1));
        sb.push_back(mk(32'h203, 2'd0, 4'b1000, 1'b0));
        sb.push_back(mk(32'h204, 2'd0, 4'b0001, 1'b1));
        issue_start(32'h100, 16'd8, scyc);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_busy_low: got %b expected 0", busy_o);
        end
        start_i = 1'b1; base_addr_i = 32'h203; len_i = 16'd2;
        @(posedge clk);
        #1 start_i = 1'b0;
        checks++;
        if (beat_valid_o !== 1'b1 || aborted_o !== 1'b0 || count_o !== 16'd0) begin
            errors++;
            $display("FAIL b2b_second_start: valid=%b ab=%b count=%0d, expected 1 0 0", beat_valid_o, aborted_o, count_o);
        end
        wait_done(seen, dcyc);
        checks++;
        if (!seen || dcyc != last_hs_cyc + 1 || count_o !== 16'd2) begin
            errors++;
            $display("FAIL b2b_done: seen=%b done_cyc=%0d last_hs=%0d count=%0d, expected count 2", seen, dcyc, last_hs_cyc, count_o);
        end
        while (sb.size() != 0) begin
            ex = sb.pop_front();
            checks++;
            if (obs.size() == 0) begin
                errors++;
                $display("FAIL b2b_beat: missing, expected %h", ex);
            end else begin
                ob = obs.pop_front();
                if (ob !== ex) begin
                    errors++;
                    $display("FAIL b2b_beat: got %h expected %h (addr,size,be,last)", ob, ex);
                end
            end
        end
        checks++;
        if (obs.size() != 0) begin
            errors++;
            $display("FAIL b2b_extra_beats: got %0d expected 0", obs.size());
            obs.delete();
        end
    endtask

    task automatic test_reset_mid;
        int scyc;
        beat_ready_i = 1'b0;
        issue_start(32'h40, 16'd16, scyc);
        @(negedge clk);
        checks++;
        if (beat_valid_o !== 1'b1 || busy_o !== 1'b1 || beat_addr_o !== 32'h40) begin
            errors++;
            $display("FAIL rst_mid_running: valid=%b busy=%b addr=%h, expected 1 1 40", beat_valid_o, busy_o, beat_addr_o);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if ({busy_o, beat_valid_o, beat_addr_o, beat_size_o, beat_be_o, beat_last_o,
             done_o, aborted_o, count_o} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: busy=%b valid=%b addr=%h size=%0d be=%b last=%b done=%b ab=%b cnt=%0d, expected all 0",
                     busy_o, beat_valid_o, beat_addr_o, beat_size_o, beat_be_o, beat_last_o,
                     done_o, aborted_o, count_o);
        end
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_no_done: done=%b busy=%b, expected 0 0", done_o, busy_o);
        end
    endtask

    initial begin
        rstn = 1'b0;
        start_i = 1'b0; abort_i = 1'b0; beat_ready_i = 1'b0;
        base_addr_i = '0; len_i = '0;
        start8 = 1'b0; abort8 = 1'b0; ready8 = 1'b1;
        base8 = '0; len8 = '0;
        test_reset();
        test_aligned();
        test_unaligned();
        test_stall();
        test_zero_len();
        test_wrap();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
